// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-to-1 stream multiplexer.
// Imported by stream_mux_nto1 and rr_arbiter.
package stream_mux_pkg;

    localparam int MIN_NUM_CH = 2;
    localparam int MIN_DATA_W = 1;

    // Select width for n channels, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Highest priority goes to the requester just after ptr.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    // Walk from farthest to nearest so the nearest requester wins
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx[SEL_W-1:0]]) begin
                gnt_idx = idx[SEL_W-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-channel valid/ready stream mux, static or round-robin select, one output register.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rr_en,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_last,
    input  logic                     out_ready
);

    if (NUM_CH < MIN_NUM_CH) begin : g_chk_ch
        $error("stream_mux_nto1: NUM_CH must be >= 2");
    end
    if (DATA_W < MIN_DATA_W) begin : g_chk_dw
        $error("stream_mux_nto1: DATA_W must be >= 1");
    end

    logic              load_en;
    logic              locked;
    logic [SEL_W-1:0]  lock_ch;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_vld;
    logic [SEL_W-1:0]  grant;
    logic              gnt_ok;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              xfer;

    assign load_en = !out_valid || out_ready;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

`ifdef STREAM_MUX_LOCK_EN
    logic             lock_q;
    logic [SEL_W-1:0] lock_ch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else if (xfer) begin
            lock_q <= !g_last;
            if (!g_last) begin
                lock_ch_q <= grant;
            end
        end
    end

    assign locked  = lock_q;
    assign lock_ch = lock_ch_q;
`else
    assign locked  = 1'b0;
    assign lock_ch = '0;
`endif

    // Static select never looks at in_valid, so no valid->ready path there
    always_comb begin
        grant  = '0;
        gnt_ok = 1'b0;
        if (locked) begin
            grant  = lock_ch;
            gnt_ok = 1'b1;
        end else if (rr_en) begin
            grant  = arb_idx;
            gnt_ok = arb_vld;
        end else begin
            grant  = sel;
            gnt_ok = int'(sel) < NUM_CH;
        end
    end

    always_comb begin
        g_valid  = 1'b0;
        g_last   = 1'b0;
        g_data   = '0;
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_ok && grant == SEL_W'(c)) begin
                g_valid     = in_valid[c];
                g_last      = in_last[c];
                g_data      = in_data[c*DATA_W +: DATA_W];
                in_ready[c] = load_en;
            end
        end
    end

    assign xfer = g_valid && load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_ch    <= grant;
            out_last  <= g_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_W'(NUM_CH - 1);
        end else if (xfer && rr_en && !locked) begin
            rr_ptr <= grant;
        end
    end

endmodule
